// File: rtl/multicycle_adder.sv
// Sequential add/subtract unit: a WIDTH-bit operation is processed CHUNK bits per clock,
// LSB first, with the inter-chunk carry held in a register behind a start/ready/done handshake.
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        FINISHED = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             c_reg, carry_reg, overflow_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [CHUNK-1:0] a_chunks [N];
    logic [CHUNK-1:0] b_chunks [N];
    logic [N-1:0]     chunk_sel;
    logic [CHUNK-1:0] a_cur, b_cur;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk, accept, overflow_chunk;

    // One-hot chunk decode keeps the per-cycle operand mux and sum write free of variable indexing.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            assign a_chunks[gi]  = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunks[gi]  = b_reg[gi*CHUNK +: CHUNK];
            assign chunk_sel[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (chunk_sel[i]) begin
                a_cur = a_cur | a_chunks[i];
                b_cur = b_cur | b_chunks[i];
            end
        end
    end

    assign chunk_sum  = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, c_reg};
    assign last_chunk = (idx_reg == IDX_W'(N - 1));
    // Carry into the chunk MSB is recovered as a^b^s at that bit, then compared with carry out.
    assign overflow_chunk = a_cur[CHUNK-1] ^ b_cur[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                if (last_chunk) state_next = FINISHED;
            end
            FINISHED: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = ready & start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            c_reg        <= 1'b0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            idx_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg   <= a;
                b_reg   <= b ^ {WIDTH{sub}};
                c_reg   <= c_in ^ sub;
                idx_reg <= '0;
            end else if (state_reg == RUN) begin
                c_reg <= chunk_sum[CHUNK];
                for (int i = 0; i < N; i++) begin
                    if (chunk_sel[i]) sum_reg[i*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                end
                if (last_chunk) begin
                    carry_reg    <= chunk_sum[CHUNK];
                    overflow_reg <= overflow_chunk;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign sum      = sum_reg;
    assign carry    = carry_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three 8-bit instances (CHUNK 4, 1, 8) checked against an
// arithmetic reference model, with directed vectors plus randomized operations.
module tb_multicycle_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_s    [3];
    logic [W-1:0] a_s        [3];
    logic [W-1:0] b_s        [3];
    logic         c_in_s     [3];
    logic         sub_s      [3];
    logic         ready_s    [3];
    logic [W-1:0] sum_s      [3];
    logic         carry_s    [3];
    logic         overflow_s [3];
    logic         done_s     [3];

    int errors = 0;
    int checks = 0;
    int lat_of [3] = '{2, 8, 1};

    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(W), .CHUNK(4)) dut_c4 (
        .clk(clk), .rst(rst), .start(start_s[0]), .ready(ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c_in(c_in_s[0]), .sub(sub_s[0]),
        .sum(sum_s[0]), .carry(carry_s[0]), .overflow(overflow_s[0]), .done(done_s[0]));

    multicycle_adder #(.WIDTH(W), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .ready(ready_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c_in(c_in_s[1]), .sub(sub_s[1]),
        .sum(sum_s[1]), .carry(carry_s[1]), .overflow(overflow_s[1]), .done(done_s[1]));

    multicycle_adder #(.WIDTH(W), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst(rst), .start(start_s[2]), .ready(ready_s[2]),
        .a(a_s[2]), .b(b_s[2]), .c_in(c_in_s[2]), .sub(sub_s[2]),
        .sum(sum_s[2]), .carry(carry_s[2]), .overflow(overflow_s[2]), .done(done_s[2]));

    // Reference: plain two's-complement arithmetic on 9-bit values.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub,
                                   output logic [W-1:0] s, output logic c, output logic v);
        logic [W:0] full;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            c    = full[W];
            v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
            c    = ~full[W];
            v    = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end
        s = full[W-1:0];
    endfunction

    // Issues one operation on instance d and returns cycles from accepting edge to DONE (99 on timeout).
    task automatic do_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, output int lat);
        @(negedge clk);
        a_s[d] = a; b_s[d] = b; c_in_s[d] = cin; sub_s[d] = sub; start_s[d] = 1'b1;
        @(posedge clk);
        #1 start_s[d] = 1'b0;
        a_s[d] = $urandom; b_s[d] = $urandom;
        lat = 99;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done_s[d] === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({ready_s[d], done_s[d], sum_s[d], carry_s[d], overflow_s[d]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset inst=%0d got ready=%b done=%b sum=%h carry=%b ovf=%b, expected 1 0 00 0 0",
                         d, ready_s[d], done_s[d], sum_s[d], carry_s[d], overflow_s[d]);
            end
        end
        $display("reset: all instances idle");
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{8'hFF, 8'h7F, 8'h10, 8'h05, 8'h80};
        logic [W-1:0] vb [5] = '{8'h01, 8'h01, 8'h20, 8'h07, 8'h01};
        logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W+1:0] exp_v [5] = '{{8'h00, 2'b10}, {8'h80, 2'b01}, {8'h31, 2'b00},
                                    {8'hFE, 2'b00}, {8'h7F, 2'b11}};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(0, va[i], vb[i], vc[i], vs[i], lat);
            checks++;
            if (lat != 2 || {sum_s[0], carry_s[0], overflow_s[0]} !== exp_v[i]) begin
                errors++;
                $display("FAIL directed %0d got lat=%0d sum/c/v=%h, expected lat=2 sum/c/v=%h",
                         i, lat, {sum_s[0], carry_s[0], overflow_s[0]}, exp_v[i]);
            end
            $display("directed %0d: a=%h b=%h cin=%b sub=%b -> sum=%h c=%b v=%b lat=%0d",
                     i, va[i], vb[i], vc[i], vs[i], sum_s[0], carry_s[0], overflow_s[0], lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, es;
        logic cin, sub, ec, ev;
        int lat;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 20; i++) begin
                a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
                ref_op(a, b, cin, sub, es, ec, ev);
                do_op(d, a, b, cin, sub, lat);
                checks++;
                if (lat != lat_of[d] || sum_s[d] !== es || carry_s[d] !== ec || overflow_s[d] !== ev) begin
                    errors++;
                    $display("FAIL random inst=%0d a=%h b=%h cin=%b sub=%b got sum=%h c=%b v=%b lat=%0d, expected sum=%h c=%b v=%b lat=%0d",
                             d, a, b, cin, sub, sum_s[d], carry_s[d], overflow_s[d], lat, es, ec, ev, lat_of[d]);
                end
                $display("random inst=%0d: a=%h b=%h cin=%b sub=%b -> sum=%h c=%b v=%b",
                         d, a, b, cin, sub, sum_s[d], carry_s[d], overflow_s[d]);
            end
        end
    endtask

    task automatic test_start_during_run();
        int lat = 99;
        @(negedge clk);
        a_s[1] = 8'hA5; b_s[1] = 8'h5B; c_in_s[1] = 1'b0; sub_s[1] = 1'b0; start_s[1] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            #1;
            // Toggle start and scramble operands on every RUN cycle; none of it may be taken.
            start_s[1] = k[0];
            a_s[1] = $urandom; b_s[1] = $urandom; sub_s[1] = $urandom;
            @(posedge clk);
            #1;
            if (done_s[1] === 1'b1) begin
                lat = k;
                break;
            end
        end
        start_s[1] = 1'b0;
        checks++;
        if (lat != 8 || {sum_s[1], carry_s[1], overflow_s[1]} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL start_in_run got lat=%0d sum=%h c=%b v=%b, expected lat=8 sum=00 c=1 v=0",
                     lat, sum_s[1], carry_s[1], overflow_s[1]);
        end
        $display("start_in_run: sum=%h c=%b lat=%0d", sum_s[1], carry_s[1], lat);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [7], ob [7], es;
        logic oc [7], os [7], ec, ev;
        for (int i = 0; i < 7; i++) begin
            oa[i] = $urandom; ob[i] = $urandom; oc[i] = $urandom; os[i] = $urandom;
        end
        @(negedge clk);
        a_s[2] = oa[0]; b_s[2] = ob[0]; c_in_s[2] = oc[0]; sub_s[2] = os[0]; start_s[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (done_s[2] !== 1'b0 || ready_s[2] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_run op=%0d got done=%b ready=%b, expected done=0 ready=0",
                         i, done_s[2], ready_s[2]);
            end
            a_s[2] = oa[i+1]; b_s[2] = ob[i+1]; c_in_s[2] = oc[i+1]; sub_s[2] = os[i+1];
            @(posedge clk);
            @(negedge clk);
            ref_op(oa[i], ob[i], oc[i], os[i], es, ec, ev);
            checks++;
            if (done_s[2] !== 1'b1 || sum_s[2] !== es || carry_s[2] !== ec || overflow_s[2] !== ev) begin
                errors++;
                $display("FAIL b2b_done op=%0d got done=%b sum=%h c=%b v=%b, expected done=1 sum=%h c=%b v=%b",
                         i, done_s[2], sum_s[2], carry_s[2], overflow_s[2], es, ec, ev);
            end
            $display("back_to_back op=%0d: a=%h b=%h cin=%b sub=%b -> sum=%h c=%b v=%b",
                     i, oa[i], ob[i], oc[i], os[i], sum_s[2], carry_s[2], overflow_s[2]);
        end
        start_s[2] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic seen_done = 1'b0;
        @(negedge clk);
        a_s[0] = 8'h33; b_s[0] = 8'h11; c_in_s[0] = 1'b0; sub_s[0] = 1'b0; start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start_s[0] = 1'b0;
        checks++;
        if ({ready_s[0], done_s[0], sum_s[0], carry_s[0], overflow_s[0]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_run_reset got ready=%b done=%b sum=%h c=%b v=%b, expected 1 0 00 0 0",
                     ready_s[0], done_s[0], sum_s[0], carry_s[0], overflow_s[0]);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_s[0] === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_no_done got done=1 after reset, expected done=0");
        end
        do_op(0, 8'h3C, 8'h0F, 1'b1, 1'b1, lat);
        checks++;
        if (lat != 2 || {sum_s[0], carry_s[0], overflow_s[0]} !== {8'h2C, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL after_reset_op got lat=%0d sum=%h c=%b v=%b, expected lat=2 sum=2c c=1 v=0",
                     lat, sum_s[0], carry_s[0], overflow_s[0]);
        end
        $display("reset_mid_run: recovered, sum=%h c=%b lat=%0d", sum_s[0], carry_s[0], lat);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0; a_s[d] = '0; b_s[d] = '0; c_in_s[d] = 1'b0; sub_s[d] = 1'b0;
        end
        test_reset();
        test_directed();
        test_random();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
